nios2_oci_dct_monitor: RTL and testbench
========================================

NIOS2_OCI_DCT_MONITOR -- requirements
Module: nios2_oci_dct_monitor

Interface
REQ-001 SHALL provide parameter DCT_W, default 30, meaning data-capture trace word width.
REQ-002 SHALL provide parameter CNT_W, default 4, meaning dct_count width.
REQ-003 SHALL provide parameter DEPTH, default 16, meaning capture FIFO entries; power of two, 2..256.
REQ-004 SHALL provide parameter WRAP, default 0, meaning 0 = drop newest when full, 1 = overwrite oldest when full.
REQ-005 SHALL use a single clock and an asynchronous, active-low reset.
REQ-006 SHALL have ports: clk  in  1  sole clock, all logic rising-edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 enable  in  1  arms capture session.
REQ-009 dct_valid  in  1  one-cycle strobe qualifying dct_buffer/dct_count.
REQ-010 dct_buffer  in  DCT_W  trace payload.
REQ-011 dct_count  in  CNT_W  trace sequence count.
REQ-012 test_ending  in  1  test end requested.
REQ-013 test_has_ended  in  1  test end complete.
REQ-014 rd_en  in  1  pop request.
REQ-015 rd_data  out  CNT_W+DCT_W  popped entry {dct_count, dct_buffer}.
REQ-016 rd_valid  out  1  rd_data valid, one cycle.
REQ-017 level  out  $clog2(DEPTH)+1  current occupancy.
REQ-018 full / empty  out  1 each  occupancy == DEPTH / == 0.
REQ-019 overflow_cnt  out  8  lost-entry count, saturating.
REQ-020 state  out  2  IDLE=0, RUN=1, DRAIN=2, DONE=3.
REQ-021 done  out  1  high exactly while state==DONE.

Function
REQ-022 SHALL transition IDLE->RUN on enable=1; any state->IDLE on enable=0 (next edge), FIFO flushed on entry to IDLE.
REQ-023 SHALL transition RUN->DRAIN on test_ending=1 or test_has_ended=1.
REQ-024 SHALL transition DRAIN->DONE when test_has_ended=1 (current or previously latched) and empty=1; test_has_ended latch clears on IDLE.
REQ-025 SHALL remain in DONE until enable=0; enable=0 has priority over all other transitions.
REQ-026 SHALL write {dct_count, dct_buffer} only when state==RUN and dct_valid=1; strobes in IDLE, DRAIN, DONE are ignored and not counted as lost.
REQ-027 SHALL pop when rd_en=1 and empty=0, in any state except IDLE; rd_data/rd_valid registered, valid the cycle after rd_en; rd_en on empty gives rd_valid=0, no state change.
REQ-028 SHALL, when full and write without concurrent pop: WRAP=0 drop write; WRAP=1 discard oldest, store new, level unchanged; both increment overflow_cnt.
REQ-029 SHALL, when write and pop coincide at full, perform both, level unchanged, overflow_cnt unchanged; rd_data is the oldest pre-write entry.
REQ-030 SHALL, when write and pop coincide at empty, perform write only (rd_valid=0), level becomes 1.
REQ-031 SHALL saturate overflow_cnt at 255; clear it on entry to IDLE.
REQ-032 SHALL wrap read/write pointers modulo DEPTH; level = writes − pops, never exceeds DEPTH.
REQ-033 SHALL keep rd_data stable when rd_valid=0.

Reset
REQ-034 SHALL, while reset_n=0, force state=IDLE, level=0, empty=1, full=0, rd_valid=0, rd_data=0, overflow_cnt=0, done=0, test_has_ended latch=0, pointers=0.
REQ-035 SHALL apply reset asynchronously mid-operation, discarding FIFO contents; first capture is possible on the second edge after release with enable=1.

Verification
REQ-036 Basic: enable=1, 3 strobes count=1,2,3 buffer=0x0000_0AA,0BB,0CC, then 3 pops -> rd_data {1,0x0AA},{2,0x0BB},{3,0x0CC}, each rd_valid one cycle after rd_en, level 3->0.
REQ-037 Overflow WRAP=0, DEPTH=16: 18 strobes payload 0..17 -> full=1, overflow_cnt=2, pops return 0..15.
REQ-038 Overflow WRAP=1, DEPTH=16: 18 strobes 0..17 -> overflow_cnt=2, pops return 2..17; 300 extra strobes -> overflow_cnt=255.
REQ-039 End sequence: 4 entries, test_ending pulse -> state=2, strobes ignored; test_has_ended pulse, 4 pops -> done=1 cycle after last pop empties FIFO; enable=0 -> state=0, overflow_cnt=0.
REQ-040 Edge/reset: write+pop at full -> level=16 unchanged; write+pop at empty -> level=1, rd_valid=0; reset_n=0 mid-RUN at level 5 -> level=0, state=0 immediately.

Source files
------------

// File: rtl/nios2_oci_dct_monitor.sv
// Data-capture trace monitor: captures {dct_count, dct_buffer} strobes into a
// FIFO while a test session runs, then drains it until the test has ended.
module nios2_oci_dct_monitor #(
  parameter int DCT_W = 30,
  parameter int CNT_W = 4,
  parameter int DEPTH = 16,
  parameter int WRAP  = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       dct_valid,
  input  logic [DCT_W-1:0]           dct_buffer,
  input  logic [CNT_W-1:0]           dct_count,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  input  logic                       rd_en,
  output logic [CNT_W+DCT_W-1:0]     rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic [7:0]                 overflow_cnt,
  output logic [1:0]                 state,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = CNT_W + DCT_W;
  localparam logic WRAP_EN = (WRAP != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_r, next_state_s;
  logic [DW-1:0]   mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]     level_r, level_nxt_s;
  logic            full_r, empty_r;
  logic [7:0]      overflow_cnt_r;
  logic [DW-1:0]   rd_data_r;
  logic            rd_valid_r;
  logic            done_r;
  logic            ended_r;
  logic            flush_s, wr_req_s, pop_s, push_s, adv_rd_s, lost_s;

  // Next-state selection; enable=0 overrides every other transition.
  always_comb begin
    next_state_s = state_r;
    if (!enable) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  next_state_s = ST_RUN;
        ST_RUN: begin
          if (test_ending || test_has_ended) next_state_s = ST_DRAIN;
          else                               next_state_s = ST_RUN;
        end
        ST_DRAIN: begin
          if ((test_has_ended || ended_r) && empty_r) next_state_s = ST_DONE;
          else                                        next_state_s = ST_DRAIN;
        end
        ST_DONE:  next_state_s = ST_DONE;
        default:  next_state_s = ST_IDLE;
      endcase
    end
  end

  // FIFO control: decide push/pop/discard and the resulting occupancy.
  always_comb begin
    flush_s     = (next_state_s == ST_IDLE);
    wr_req_s    = (state_r == ST_RUN) && dct_valid && !flush_s;
    pop_s       = rd_en && !empty_r && (state_r != ST_IDLE) && !flush_s;
    push_s      = 1'b0;
    adv_rd_s    = pop_s;
    lost_s      = 1'b0;
    level_nxt_s = level_r;
    if (full_r && wr_req_s && !pop_s) begin
      // Full with no pop to make room: either drop the new word or evict the oldest.
      lost_s = 1'b1;
      if (WRAP_EN) begin
        push_s   = 1'b1;
        adv_rd_s = 1'b1;
      end else begin
        push_s   = 1'b0;
        adv_rd_s = 1'b0;
      end
    end else begin
      push_s = wr_req_s;
    end
    if (flush_s) begin
      level_nxt_s = '0;
    end else if (push_s && !adv_rd_s) begin
      level_nxt_s = level_r + (AW+1)'(1);
    end else if (!push_s && adv_rd_s) begin
      level_nxt_s = level_r - (AW+1)'(1);
    end else begin
      level_nxt_s = level_r;
    end
  end

  // State, pointers, occupancy flags, loss counter and read port registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      done_r         <= 1'b0;
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      level_r        <= '0;
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      overflow_cnt_r <= 8'd0;
      rd_data_r      <= '0;
      rd_valid_r     <= 1'b0;
    end else begin
      state_r <= next_state_s;
      done_r  <= (next_state_s == ST_DONE);
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == (AW+1)'(DEPTH));
      empty_r <= (level_nxt_s == (AW+1)'(0));
      if (flush_s) begin
        wr_ptr_r       <= '0;
        rd_ptr_r       <= '0;
        overflow_cnt_r <= 8'd0;
        rd_valid_r     <= 1'b0;
      end else begin
        if (push_s)   wr_ptr_r <= wr_ptr_r + AW'(1);
        if (adv_rd_s) rd_ptr_r <= rd_ptr_r + AW'(1);
        if (lost_s && (overflow_cnt_r != 8'hFF)) overflow_cnt_r <= overflow_cnt_r + 8'd1;
        rd_valid_r <= pop_s;
        // Read happens before the same-edge write, so a pop at full returns the oldest word.
        if (pop_s) rd_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= {dct_count, dct_buffer};
  end

  // Remember a test_has_ended pulse seen before the FIFO finished draining.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            ended_r <= 1'b0;
    else if (flush_s)        ended_r <= 1'b0;
    else if (test_has_ended) ended_r <= 1'b1;
    else                     ended_r <= ended_r;
  end

  assign state        = state_r;
  assign done         = done_r;
  assign level        = level_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign overflow_cnt = overflow_cnt_r;
  assign rd_data      = rd_data_r;
  assign rd_valid     = rd_valid_r;

endmodule

// File: tb/tb_nios2_oci_dct_monitor.sv
// Directed bench for nios2_oci_dct_monitor; two instances (drop and wrap modes)
// share the same stimulus.
module tb_nios2_oci_dct_monitor;

  localparam int DCT_W = 30;
  localparam int CNT_W = 4;
  localparam int DW    = 34;

  logic             clk = 1'b0;
  logic             reset_n, enable, dct_valid, test_ending, test_has_ended, rd_en;
  logic [DCT_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, full0, full1, empty0, empty1, done0, done1;
  logic [4:0]    level0, level1;
  logic [7:0]    ovf0, ovf1;
  logic [1:0]    state0, state1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios2_oci_dct_monitor #(.DCT_W(30), .CNT_W(4), .DEPTH(16), .WRAP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .dct_valid(dct_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .rd_en(rd_en), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .level(level0), .full(full0), .empty(empty0),
    .overflow_cnt(ovf0), .state(state0), .done(done0));

  nios2_oci_dct_monitor #(.DCT_W(30), .CNT_W(4), .DEPTH(16), .WRAP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .dct_valid(dct_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .rd_en(rd_en), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .level(level1), .full(full1), .empty(empty1),
    .overflow_cnt(ovf1), .state(state1), .done(done1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] entry(input int c, input int b);
    logic [CNT_W-1:0] cc;
    logic [DCT_W-1:0] bb;
    cc = CNT_W'(c);
    bb = DCT_W'(b);
    return {cc, bb};
  endfunction

  initial begin
    reset_n = 1'b0; enable = 1'b0; dct_valid = 1'b0; test_ending = 1'b0;
    test_has_ended = 1'b0; rd_en = 1'b0; dct_buffer = '0; dct_count = '0;
    repeat (3) tick();

    // Reset state
    check("rst_state", 64'(state0), 64'd0);
    check("rst_level", 64'(level0), 64'd0);
    check("rst_empty", 64'(empty0), 64'd1);
    check("rst_full", 64'(full0), 64'd0);
    check("rst_rd_valid", 64'(rd_valid0), 64'd0);
    check("rst_rd_data", 64'(rd_data0), 64'd0);
    check("rst_ovf", 64'(ovf0), 64'd0);
    check("rst_done", 64'(done1), 64'd0);

    reset_n = 1'b1; enable = 1'b1;
    tick();
    check("run_state", 64'(state0), 64'd1);

    // Basic capture and pop
    dct_valid = 1'b1;
    dct_count = 4'd1; dct_buffer = 30'h0AA; tick();
    dct_count = 4'd2; dct_buffer = 30'h0BB; tick();
    dct_count = 4'd3; dct_buffer = 30'h0CC; tick();
    dct_valid = 1'b0;
    check("basic_level3", 64'(level0), 64'd3);
    rd_en = 1'b1;
    tick();
    check("pop1_valid", 64'(rd_valid0), 64'd1);
    check("pop1_data", 64'(rd_data0), 64'(entry(1, 32'h0AA)));
    check("pop1_level", 64'(level0), 64'd2);
    tick();
    check("pop2_data", 64'(rd_data0), 64'(entry(2, 32'h0BB)));
    tick();
    check("pop3_data", 64'(rd_data0), 64'(entry(3, 32'h0CC)));
    check("pop3_level", 64'(level0), 64'd0);
    check("pop3_empty", 64'(empty0), 64'd1);
    rd_en = 1'b0;
    tick();
    check("idle_rd_valid", 64'(rd_valid0), 64'd0);
    check("stable_rd_data", 64'(rd_data0), 64'(entry(3, 32'h0CC)));
    rd_en = 1'b1;
    tick();
    check("pop_empty_valid", 64'(rd_valid0), 64'd0);
    check("pop_empty_level", 64'(level0), 64'd0);
    rd_en = 1'b0;

    // Overflow: 18 strobes into a 16-deep FIFO
    dct_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      dct_count = CNT_W'(i); dct_buffer = DCT_W'(i); tick();
    end
    dct_valid = 1'b0;
    check("ovf_full0", 64'(full0), 64'd1);
    check("ovf_full1", 64'(full1), 64'd1);
    check("ovf_level0", 64'(level0), 64'd16);
    check("ovf_cnt0", 64'(ovf0), 64'd2);
    check("ovf_cnt1", 64'(ovf1), 64'd2);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("drop_pop", 64'(rd_data0), 64'(entry(i, i)));
      check("wrap_pop", 64'(rd_data1), 64'(entry(i + 2, i + 2)));
    end
    rd_en = 1'b0;
    tick();
    check("ovf_drained0", 64'(empty0), 64'd1);
    check("ovf_drained1", 64'(level1), 64'd0);

    // Refill to full, then simultaneous write and pop at full
    dct_valid = 1'b1; dct_count = 4'd0;
    for (int i = 0; i < 16; i++) begin
      dct_buffer = DCT_W'(32'h200 + i); tick();
    end
    check("refill_full", 64'(level0), 64'd16);
    dct_buffer = 30'h100; rd_en = 1'b1;
    tick();
    rd_en = 1'b0; dct_valid = 1'b0;
    check("wp_full_level0", 64'(level0), 64'd16);
    check("wp_full_level1", 64'(level1), 64'd16);
    check("wp_full_data0", 64'(rd_data0), 64'(entry(0, 32'h200)));
    check("wp_full_data1", 64'(rd_data1), 64'(entry(0, 32'h200)));
    check("wp_full_ovf0", 64'(ovf0), 64'd2);
    check("wp_full_ovf1", 64'(ovf1), 64'd2);

    // Saturate the loss counter
    dct_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      dct_buffer = DCT_W'(i); tick();
    end
    dct_valid = 1'b0;
    check("sat_ovf0", 64'(ovf0), 64'd255);
    check("sat_ovf1", 64'(ovf1), 64'd255);
    check("sat_level1", 64'(level1), 64'd16);

    // Disable flushes everything
    enable = 1'b0;
    tick();
    check("flush_state", 64'(state0), 64'd0);
    check("flush_level", 64'(level1), 64'd0);
    check("flush_ovf", 64'(ovf1), 64'd0);
    check("flush_empty", 64'(empty0), 64'd1);

    // Write and pop together at empty
    enable = 1'b1;
    tick();
    dct_valid = 1'b1; rd_en = 1'b1; dct_buffer = 30'h055;
    tick();
    dct_valid = 1'b0; rd_en = 1'b0;
    check("wp_empty_level", 64'(level0), 64'd1);
    check("wp_empty_valid", 64'(rd_valid0), 64'd0);

    // End-of-test sequence
    enable = 1'b0; tick();
    enable = 1'b1; tick();
    dct_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dct_count = CNT_W'(i); dct_buffer = DCT_W'(32'h10 + i); tick();
    end
    dct_valid = 1'b0;
    check("end_level4", 64'(level0), 64'd4);
    test_ending = 1'b1; tick(); test_ending = 1'b0;
    check("end_drain", 64'(state0), 64'd2);
    dct_valid = 1'b1; tick(); dct_valid = 1'b0;
    check("drain_ignore_level", 64'(level0), 64'd4);
    check("drain_ignore_ovf", 64'(ovf0), 64'd0);
    test_has_ended = 1'b1; tick(); test_has_ended = 1'b0;
    check("ended_still_drain", 64'(state0), 64'd2);
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_pop", 64'(rd_data0), 64'(entry(i, 32'h10 + i)));
    end
    rd_en = 1'b0;
    check("last_pop_state", 64'(state0), 64'd2);
    check("last_pop_done", 64'(done0), 64'd0);
    tick();
    check("done_state", 64'(state0), 64'd3);
    check("done_flag", 64'(done0), 64'd1);
    tick();
    check("done_hold", 64'(done1), 64'd1);
    enable = 1'b0; tick();
    check("exit_state", 64'(state0), 64'd0);
    check("exit_done", 64'(done0), 64'd0);
    check("exit_ovf", 64'(ovf0), 64'd0);

    // Asynchronous reset mid-RUN at level 5
    enable = 1'b1; tick();
    dct_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dct_buffer = DCT_W'(i); tick();
    end
    dct_valid = 1'b0;
    check("pre_rst_level", 64'(level0), 64'd5);
    reset_n = 1'b0;
    #1;
    check("async_rst_level", 64'(level0), 64'd0);
    check("async_rst_state", 64'(state0), 64'd0);
    check("async_rst_empty", 64'(empty1), 64'd1);
    tick();
    reset_n = 1'b1; dct_valid = 1'b1; dct_buffer = 30'h3;
    tick();
    check("post_rst_edge1_state", 64'(state0), 64'd1);
    check("post_rst_edge1_level", 64'(level0), 64'd0);
    tick();
    dct_valid = 1'b0;
    check("post_rst_edge2_level", 64'(level0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
